// File: rtl/irq_request_latch.sv
// Request front end for the 8-to-3 priority encoder: captures rising edges
// into sticky pending bits and presents a held, masked snapshot until acknowledged.
module irq_request_latch #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [N-1:0]   irq_in,
    input  logic [N-1:0]   mask,
    input  logic           ack,
    input  logic [IDW-1:0] ack_id,
    output logic [N-1:0]   req_vec,
    output logic           req_valid,
    output logic [N-1:0]   pending,
    output logic [N-1:0]   ovr,
    output logic           ack_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state_r;
    logic [N-1:0]   prev_r;
    logic [N-1:0]   rise_s;
    logic [N-1:0]   avail_s;
    logic [N-1:0]   clr_s;
    logic [N-1:0]   one_s;
    logic           legal_ack_s;

    // Edge detect, presentable set, and the one-hot clear of a legal acknowledge.
    always_comb begin
        one_s       = {{(N-1){1'b0}}, 1'b1};
        rise_s      = irq_in & ~prev_r;
        avail_s     = pending & ~mask;
        legal_ack_s = 1'b0;
        clr_s       = {N{1'b0}};
        if (en && ack && (state_r == HOLD) && req_vec[ack_id]) begin
            legal_ack_s = 1'b1;
            clr_s       = one_s << ack_id;
        end else begin
            legal_ack_s = 1'b0;
            clr_s       = {N{1'b0}};
        end
    end

    // Sticky capture: a rise beats a same-edge clear, but the clear still wipes overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_r  <= {N{1'b1}};
            pending <= {N{1'b0}};
            ovr     <= {N{1'b0}};
        end else begin
            prev_r  <= irq_in;
            pending <= (pending & ~clr_s) | rise_s;
            ovr     <= (ovr | (rise_s & pending)) & ~clr_s;
        end
    end

    // Presentation FSM: snapshot in IDLE, freeze in HOLD until a legal ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            req_vec   <= {N{1'b0}};
            req_valid <= 1'b0;
            ack_err   <= 1'b0;
        end else begin
            ack_err <= 1'b0;
            if (!en) begin
                state_r   <= IDLE;
                req_vec   <= {N{1'b0}};
                req_valid <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (ack) begin
                            ack_err <= 1'b1;
                        end
                        if (avail_s != {N{1'b0}}) begin
                            req_vec   <= avail_s;
                            req_valid <= 1'b1;
                            state_r   <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (legal_ack_s) begin
                            req_vec   <= {N{1'b0}};
                            req_valid <= 1'b0;
                            state_r   <= IDLE;
                        end else if (ack) begin
                            ack_err <= 1'b1;
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        req_vec   <= {N{1'b0}};
                        req_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed bench for irq_request_latch; inputs change 1ns after each rising edge,
// outputs are sampled there too, so each check sees the result of the preceding edge.
module tb_irq_request_latch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] irq_in;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] ack_id;
    logic [7:0] req_vec;
    logic       req_valid;
    logic [7:0] pending;
    logic [7:0] ovr;
    logic       ack_err;

    int n_checks = 0;
    int n_fail   = 0;

    irq_request_latch #(.N(8), .IDW(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .irq_in(irq_in), .mask(mask),
        .ack(ack), .ack_id(ack_id), .req_vec(req_vec), .req_valid(req_valid),
        .pending(pending), .ovr(ovr), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic ack_once(input logic [2:0] id);
        ack    = 1'b1;
        ack_id = id;
        step();
        ack    = 1'b0;
        ack_id = 3'd0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; irq_in = 8'h00; mask = 8'h00; ack = 1'b0; ack_id = 3'd0;
        step(); step();
        chk8("rst_pending", pending, 8'h00);
        chk8("rst_ovr", ovr, 8'h00);
        chk8("rst_req_vec", req_vec, 8'h00);
        chk1("rst_req_valid", req_valid, 1'b0);
        chk1("rst_ack_err", ack_err, 1'b0);

        // Basic single line: two-cycle latency, then ack id 0
        rst_n = 1'b1; en = 1'b1;
        step();
        irq_in = 8'h01;
        step();
        chk8("t1_pending", pending, 8'h01);
        chk1("t1_valid_early", req_valid, 1'b0);
        step();
        chk1("t1_valid", req_valid, 1'b1);
        chk8("t1_req_vec", req_vec, 8'h01);
        ack_once(3'd0);
        chk1("t1_valid_after_ack", req_valid, 1'b0);
        chk8("t1_pending_after_ack", pending, 8'h00);
        chk1("t1_no_ack_err", ack_err, 1'b0);
        irq_in = 8'h00;
        step();

        // Multi-line snapshot frozen against new rises
        irq_in = 8'h0F;
        step();
        chk8("t2_pending", pending, 8'h0F);
        step();
        chk8("t2_req_vec", req_vec, 8'h0F);
        irq_in = 8'h8F;
        step();
        chk8("t2_pending_8f", pending, 8'h8F);
        chk8("t2_req_vec_frozen", req_vec, 8'h0F);
        ack_once(3'd3);
        chk1("t2_bubble", req_valid, 1'b0);
        chk8("t2_pending_87", pending, 8'h87);
        step();
        chk1("t2_valid_again", req_valid, 1'b1);
        chk8("t2_req_vec_87", req_vec, 8'h87);
        ack_once(3'd0);
        step();
        chk8("t2_req_vec_86", req_vec, 8'h86);
        ack_once(3'd1); step();
        ack_once(3'd2); step();
        chk8("t2_req_vec_80", req_vec, 8'h80);
        ack_once(3'd7);
        chk8("t2_pending_clear", pending, 8'h00);
        chk1("t2_valid_clear", req_valid, 1'b0);
        irq_in = 8'h00;
        step();

        // Overrun on a second rise before ack; ack clears both
        irq_in = 8'h04;
        step(); step();
        chk8("t3_req_vec", req_vec, 8'h04);
        irq_in = 8'h00;
        step();
        irq_in = 8'h04;
        step();
        chk8("t3_ovr", ovr, 8'h04);
        chk8("t3_pending", pending, 8'h04);
        ack_once(3'd2);
        chk8("t3_ovr_cleared", ovr, 8'h00);
        chk8("t3_pending_cleared", pending, 8'h00);
        irq_in = 8'h00;
        step();

        // Masked pending stays unpresented; unmasking presents it
        mask = 8'hFF; irq_in = 8'h10;
        step();
        chk8("t4_pending", pending, 8'h10);
        for (int i = 0; i < 10; i++) begin
            step();
            chk1("t4_masked_idle", req_valid, 1'b0);
        end
        mask = 8'h00;
        step();
        chk1("t4_unmask_valid", req_valid, 1'b1);
        chk8("t4_unmask_req_vec", req_vec, 8'h10);

        // Illegal ack in HOLD, then ack in IDLE
        ack_once(3'd5);
        chk1("t5_ack_err_hold", ack_err, 1'b1);
        chk1("t5_still_valid", req_valid, 1'b1);
        chk8("t5_req_vec_kept", req_vec, 8'h10);
        chk8("t5_pending_kept", pending, 8'h10);
        step();
        chk1("t5_ack_err_pulse_end", ack_err, 1'b0);
        ack_once(3'd4);
        chk8("t5_pending_cleared", pending, 8'h00);
        chk1("t5_idle", req_valid, 1'b0);
        ack_once(3'd0);
        chk1("t5_ack_err_idle", ack_err, 1'b1);
        step();
        chk1("t5_ack_err_idle_end", ack_err, 1'b0);
        irq_in = 8'h00;
        step();

        // Rise and legal clear on the same edge: set wins, no overrun
        irq_in = 8'h02;
        step(); step();
        chk8("t6_req_vec", req_vec, 8'h02);
        irq_in = 8'h00;
        step();
        irq_in = 8'h02;
        ack_once(3'd1);
        chk8("t6_pending_set_wins", pending, 8'h02);
        chk8("t6_no_ovr", ovr, 8'h00);
        chk1("t6_bubble", req_valid, 1'b0);
        step();
        chk8("t6_represent", req_vec, 8'h02);
        ack_once(3'd1);
        chk8("t6_pending_clear", pending, 8'h00);

        // Reset mid-HOLD with lines held high across release
        irq_in = 8'hFF;
        step(); step();
        chk8("t7_hold_vec", req_vec, 8'hFD);
        rst_n = 1'b0;
        step();
        chk1("t7_rst_valid", req_valid, 1'b0);
        chk8("t7_rst_pending", pending, 8'h00);
        chk1("t7_rst_ack_err", ack_err, 1'b0);
        rst_n = 1'b1;
        step(); step();
        chk8("t7_no_edge_pending", pending, 8'h00);
        chk1("t7_no_edge_valid", req_valid, 1'b0);

        // Drop en mid-HOLD, ack ignored while disabled, re-present on enable
        irq_in = 8'h00;
        step();
        irq_in = 8'h20;
        step(); step();
        chk8("t8_req_vec", req_vec, 8'h20);
        en = 1'b0;
        step();
        chk1("t8_en_off_valid", req_valid, 1'b0);
        chk8("t8_en_off_vec", req_vec, 8'h00);
        chk8("t8_en_off_pending", pending, 8'h20);
        ack_once(3'd5);
        chk1("t8_en_off_no_ack_err", ack_err, 1'b0);
        chk8("t8_en_off_pending2", pending, 8'h20);
        en = 1'b1;
        step();
        chk1("t8_en_on_valid", req_valid, 1'b1);
        chk8("t8_en_on_vec", req_vec, 8'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
